// File: rtl/delay_chain_sensor_ctrl_pkg.sv
// Shared definitions for the spy delay-chain sensor: FSM encodings and default sizing.
package delay_chain_sensor_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_CHECK   = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_REPORT  = 3'd5
  } sensor_state_e;

  localparam int DEF_CAPTURE_DLY = 1;
  localparam int DEF_SETTLE_CYC  = 8;
  localparam int DEF_TRIAL_W     = 16;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/spy_sync2.sv
// Two-flop synchronizer for the chain output, used only for the post-settle sanity check.
module spy_sync2 (
  input  logic clk,
  input  logic rstN,
  input  logic d,
  output logic q
);

  logic meta;

  // Plain 2-stage resync; reset to 0 to match the reset level of the chain drive.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/delay_chain_sensor_ctrl.sv
// Trial sequencer for a spy delay chain: launch an edge, capture the raw chain output a
// fixed number of clocks later, count late arrivals, and report the count by valid/ready.
module delay_chain_sensor_ctrl
  import delay_chain_sensor_ctrl_pkg::*;
#(
  parameter int CAPTURE_DLY = DEF_CAPTURE_DLY,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int TRIAL_W     = DEF_TRIAL_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter bit INVERT      = 1'b0
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               start,
  input  logic               abort,
  input  logic [TRIAL_W-1:0] numTrials,
  (* keep = 1 *) output logic pathInput,
  (* keep = 1 *) input  logic pathResult,
  output logic               busy,
  output logic [CNT_W-1:0]   faultCount,
  output logic               stuckErr,
  output logic               resultValid,
  input  logic               resultReady
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  sensor_state_e       state;
  logic [3:0]          dlyCnt;
  logic [SC_W-1:0]     settleCnt;
  logic [TRIAL_W-1:0]  trialCnt;
  logic                expBit;
  logic                syncQ;
  (* keep = 1 *) logic capQ;

  // Raw capture of the chain output, deliberately unsynchronized: sampling a late
  // transition is the measurement. CHECK gives it a full clock to resolve.
  always_ff @(posedge clk) begin
    if (state == ST_CAPTURE && dlyCnt == 4'd0) capQ <= pathResult;
  end

  spy_sync2 uSync (
    .clk  (clk),
    .rstN (rstN),
    .d    (pathResult),
    .q    (syncQ)
  );

  // Trial sequencer; all outputs registered. abort overrides start and resultReady.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state       <= ST_IDLE;
      pathInput   <= 1'b0;
      busy        <= 1'b0;
      resultValid <= 1'b0;
      stuckErr    <= 1'b0;
      faultCount  <= '0;
      trialCnt    <= '0;
      dlyCnt      <= '0;
      settleCnt   <= '0;
      expBit      <= 1'b0;
    end else if (abort && state != ST_IDLE) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      resultValid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            trialCnt   <= numTrials;
            faultCount <= '0;
            stuckErr   <= 1'b0;
            busy       <= 1'b1;
            if (numTrials == '0) begin
              state       <= ST_REPORT;
              resultValid <= 1'b1;
            end else begin
              state <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          pathInput <= ~pathInput;
          expBit    <= ~pathInput ^ INVERT;
          dlyCnt    <= 4'(CAPTURE_DLY - 1);
          state     <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (dlyCnt == 4'd0) state <= ST_CHECK;
          else                dlyCnt <= dlyCnt - 4'd1;
        end
        ST_CHECK: begin
          if (capQ != expBit && faultCount != {CNT_W{1'b1}})
            faultCount <= faultCount + 1'b1;
          settleCnt <= SC_W'(SETTLE_CYC - 1);
          state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settleCnt == '0) begin
            if (syncQ != expBit) stuckErr <= 1'b1;
            trialCnt <= trialCnt - 1'b1;
            if (trialCnt == TRIAL_W'(1)) begin
              state       <= ST_REPORT;
              resultValid <= 1'b1;
            end else begin
              state <= ST_LAUNCH;
            end
          end else begin
            settleCnt <= settleCnt - 1'b1;
          end
        end
        ST_REPORT: begin
          if (resultReady) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            resultValid <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          resultValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_chain_sensor_ctrl.sv
// Directed bench: behavioural delay-chain model with programmable delay driving two
// sensor instances (default counter width and a 4-bit counter for saturation).
`timescale 1ns/1ps
module tb_delay_chain_sensor_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start, abort, resultReady;
  logic [15:0] numTrials;

  logic        piA, piB, prA, prB, chainA, chainB;
  logic        busyA, busyB, stuckA, stuckB, rvA, rvB;
  logic [15:0] fcA;
  logic [3:0]  fcB;

  int  td   = 3;
  bit  tie0 = 1'b0;
  int  nAsserts = 0;
  int  nFails   = 0;

  always #5 clk = ~clk;

  // Transport-delay chain model, optionally stuck at 0.
  initial begin chainA = 1'b0; chainB = 1'b0; end
  always @(piA) chainA <= #(td) piA;
  always @(piB) chainB <= #(td) piB;
  assign prA = tie0 ? 1'b0 : chainA;
  assign prB = tie0 ? 1'b0 : chainB;

  delay_chain_sensor_ctrl dutA (
    .clk(clk), .rstN(rstN), .start(start), .abort(abort), .numTrials(numTrials),
    .pathInput(piA), .pathResult(prA), .busy(busyA), .faultCount(fcA),
    .stuckErr(stuckA), .resultValid(rvA), .resultReady(resultReady)
  );

  delay_chain_sensor_ctrl #(.CNT_W(4)) dutB (
    .clk(clk), .rstN(rstN), .start(start), .abort(abort), .numTrials(numTrials),
    .pathInput(piB), .pathResult(prB), .busy(busyB), .faultCount(fcB),
    .stuckErr(stuckB), .resultValid(rvB), .resultReady(resultReady)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] n);
    numTrials = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts clocks after the start edge until resultValid; bounded.
  task automatic waitResult(output int n);
    n = 0;
    while (!rvA && n < 3000) begin
      tick();
      n++;
    end
    if (!rvA) chk("result_timeout", 0, 1);
  endtask

  task automatic ack();
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
  endtask

  initial begin
    int n;
    bit stable;
    logic        piSave;
    logic [15:0] fcSave;

    rstN = 1'b0; start = 1'b0; abort = 1'b0; resultReady = 1'b0; numTrials = '0;
    tick(); tick();
    chk("rst_busy", busyA, 0);
    chk("rst_valid", rvA, 0);
    chk("rst_pathInput", piA, 0);
    chk("rst_faultCount", fcA, 0);
    chk("rst_stuckErr", stuckA, 0);
    rstN = 1'b1;
    tick();

    // Fast chain: no faults, 100 trials x 11 clks.
    td = 3;
    launch(16'd100);
    waitResult(n);
    chk("t1_latency", n, 1100);
    chk("t1_faults", fcA, 0);
    chk("t1_stuck", stuckA, 0);
    ack();

    // Slow chain: every capture is late; then a held-off handshake with a stray start.
    td = 25;
    launch(16'd100);
    waitResult(n);
    chk("t2_faults", fcA, 100);
    chk("t2_stuck", stuckA, 0);
    stable = 1'b1;
    fcSave = fcA;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin numTrials = 16'd0; start = 1'b1; end
      tick();
      start = 1'b0;
      if (!rvA || !busyA || fcA != fcSave || stuckA) stable = 1'b0;
    end
    chk("t4_hold_stable", stable, 1);
    ack();
    chk("t4_valid_drop", rvA, 0);
    chk("t4_idle_busy", busyA, 0);

    // Zero trials: straight to REPORT, chain untouched.
    piSave = piA;
    launch(16'd0);
    chk("t3_valid_next", rvA, 1);
    chk("t3_faults", fcA, 0);
    chk("t3_pathInput", piA, piSave);
    ack();

    // Chain output stuck low: half the expected levels are 1.
    tie0 = 1'b1;
    launch(16'd100);
    waitResult(n);
    chk("t6_faults", fcA, 50);
    chk("t6_stuck", stuckA, 1);
    ack();
    tie0 = 1'b0;
    repeat (5) tick();

    // Saturation on the narrow counter.
    td = 25;
    launch(16'd20);
    waitResult(n);
    chk("t7_faults_wide", fcA, 20);
    chk("t7_faults_sat", fcB, 15);
    chk("t7_stuck_cleared", stuckA, 0);
    ack();

    // Abort during trial 40 (its LAUNCH cycle), then reset during a second run.
    td = 3;
    launch(16'd100);
    repeat (39 * 11) tick();
    piSave = piA;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_busy", busyA, 0);
    chk("t5_abort_valid", rvA, 0);
    chk("t5_abort_pathInput", piA, piSave);
    stable = 1'b1;
    repeat (20) begin tick(); if (rvA || busyA) stable = 1'b0; end
    chk("t5_no_result", stable, 1);
    launch(16'd100);
    repeat (19 * 11 + 3) tick();
    rstN = 1'b0;
    tick();
    chk("t5_rst_busy", busyA, 0);
    chk("t5_rst_valid", rvA, 0);
    chk("t5_rst_pathInput", piA, 0);
    chk("t5_rst_faults", fcA, 0);
    rstN = 1'b1;
    stable = 1'b1;
    repeat (20) begin tick(); if (rvA || busyA) stable = 1'b0; end
    chk("t5_rst_no_result", stable, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
